// File: rtl/enemy_respawn_scheduler_pkg.sv
// Shared constants and types for the enemy respawn scheduler.
// Group indices, default index ranges of the alive vector, per-group FSM states.
package enemy_pkg;

  localparam int NUM_GRP    = 3;
  localparam int GRP_FLY    = 0;
  localparam int GRP_SPIDER = 1;
  localparam int GRP_MOSQ   = 2;

  localparam int ENEMY_COUNT_DEF = 23;
  localparam int ENEMY_FLY_LO    = 0;
  localparam int ENEMY_FLY_HI    = 16;
  localparam int ENEMY_SPIDER_LO = 17;
  localparam int ENEMY_SPIDER_HI = 20;
  localparam int ENEMY_MOSQ_LO   = 21;
  localparam int ENEMY_MOSQ_HI   = 22;

  typedef enum logic [1:0] {ALIVE, COOLDOWN, REQ, SETTLE} grp_state_e;

  // Counter width able to hold 0..max_val, never narrower than one bit.
  function automatic int bits_for(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/enemy_respawn_scheduler_group_timer.sv
// One enemy group's respawn FSM: frame-tick cooldown, request, then a
// bounded wait for the respawned enemies to read back alive.
module enemy_group_timer
  import enemy_pkg::*;
#(
  parameter int RESPAWN_FRAMES = 120,
  parameter int SETTLE_MAX     = 4
) (
  input  logic clk25,
  input  logic rst_n,
  input  logic enable,
  input  logic frame_tick,
  input  logic grp_dead,
  input  logic grp_any_alive,
  input  logic grant,
  output logic req,
  output logic cleared,
  output logic busy
);

  localparam int CW = bits_for(RESPAWN_FRAMES);
  localparam int SW = bits_for(SETTLE_MAX);

  grp_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] scnt_q, scnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    scnt_d  = scnt_q;
    case (state_q)
      ALIVE:
        if (enable && grp_dead) begin
          state_d = COOLDOWN;
          cnt_d   = CW'(RESPAWN_FRAMES);
        end
      COOLDOWN:
        // Zero is tested before ticks, so a zero cooldown spends one cycle here.
        if (cnt_q == '0)                state_d = REQ;
        else if (enable && frame_tick)  cnt_d   = cnt_q - CW'(1);
      REQ:
        if (grant) begin
          state_d = SETTLE;
          scnt_d  = '0;
        end
      SETTLE:
        if (grp_any_alive || scnt_q == SW'(SETTLE_MAX - 1)) state_d = ALIVE;
        else                                              scnt_d  = scnt_q + SW'(1);
      default: state_d = ALIVE;
    endcase
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ALIVE;
      cnt_q   <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scnt_q  <= scnt_d;
    end
  end

  assign req     = (state_q == REQ);
  assign cleared = (state_q == COOLDOWN) || (state_q == REQ);
  assign busy    = (state_q != ALIVE);

endmodule

// File: rtl/enemy_respawn_scheduler.sv
// Enemy respawn scheduler: three group timers, fixed-priority respawn arbiter
// and saturating HUD wave counter. Define SCHED_ALL_CLEAR_EN to start cooldown
// only when every enemy is dead, for all groups together.
module enemy_respawn_scheduler
  import enemy_pkg::*;
#(
  parameter int ENEMY_COUNT    = ENEMY_COUNT_DEF,
  parameter int FLY_LO         = ENEMY_FLY_LO,
  parameter int FLY_HI         = ENEMY_FLY_HI,
  parameter int SPIDER_LO      = ENEMY_SPIDER_LO,
  parameter int SPIDER_HI      = ENEMY_SPIDER_HI,
  parameter int MOSQ_LO        = ENEMY_MOSQ_LO,
  parameter int MOSQ_HI        = ENEMY_MOSQ_HI,
  parameter int RESPAWN_FRAMES = 120,
  parameter int SETTLE_MAX     = 4,
  parameter int WAVE_W         = 8
) (
  input  logic                   clk25,
  input  logic                   rst_n,
  input  logic                   frame_tick,
  input  logic                   enable,
  input  logic [ENEMY_COUNT-1:0] enemy_alive_flat,
  output logic                   reset_fly,
  output logic                   reset_spider,
  output logic                   reset_mosquito,
  output logic [NUM_GRP-1:0]     group_cleared,
  output logic [WAVE_W-1:0]      wave,
  output logic                   busy
);

  logic [NUM_GRP-1:0] grp_any, grp_dead, req, grant, busy_g;
  logic [NUM_GRP-1:0] pulse_q, pulse_d;
  logic [WAVE_W-1:0]  wave_q, wave_d;

  assign grp_any[GRP_FLY]    = |enemy_alive_flat[FLY_HI:FLY_LO];
  assign grp_any[GRP_SPIDER] = |enemy_alive_flat[SPIDER_HI:SPIDER_LO];
  assign grp_any[GRP_MOSQ]   = |enemy_alive_flat[MOSQ_HI:MOSQ_LO];

`ifdef SCHED_ALL_CLEAR_EN
  assign grp_dead = {NUM_GRP{~|enemy_alive_flat}};
`else
  assign grp_dead = ~grp_any;
`endif

  for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
    enemy_group_timer #(
      .RESPAWN_FRAMES (RESPAWN_FRAMES),
      .SETTLE_MAX     (SETTLE_MAX)
    ) u_timer (
      .clk25         (clk25),
      .rst_n         (rst_n),
      .enable        (enable),
      .frame_tick    (frame_tick),
      .grp_dead      (grp_dead[g]),
      .grp_any_alive (grp_any[g]),
      .grant         (grant[g]),
      .req           (req[g]),
      .cleared       (group_cleared[g]),
      .busy          (busy_g[g])
    );
  end

  // Lowest group index wins; a paused game grants nothing and requests wait.
  always_comb begin
    grant = '0;
    if (enable) begin
      if      (req[GRP_FLY])    grant[GRP_FLY]    = 1'b1;
      else if (req[GRP_SPIDER]) grant[GRP_SPIDER] = 1'b1;
      else if (req[GRP_MOSQ])   grant[GRP_MOSQ]   = 1'b1;
    end
    pulse_d = grant;
    wave_d  = (pulse_q[GRP_FLY] && wave_q != '1) ? wave_q + WAVE_W'(1) : wave_q;
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q <= '0;
      wave_q  <= '0;
    end else begin
      pulse_q <= pulse_d;
      wave_q  <= wave_d;
    end
  end

  assign reset_fly      = pulse_q[GRP_FLY];
  assign reset_spider   = pulse_q[GRP_SPIDER];
  assign reset_mosquito = pulse_q[GRP_MOSQ];
  assign wave           = wave_q;
  assign busy           = |busy_g;

endmodule

// File: tb/tb_enemy_respawn_scheduler.sv
// Bench for enemy_respawn_scheduler: directed table, reset/abort sequence and
// randomized traffic, all checked against a rule-level model of respawn timing.
module tb_enemy_respawn_scheduler;

  localparam int RF = 3;
  localparam int SM = 4;
  localparam logic [22:0] ALL   = 23'h7FFFFF;
  localparam logic [22:0] FLY_M = 23'h01FFFF;
  localparam logic [22:0] SPI_M = 23'h1E0000;
  localparam logic [22:0] MOS_M = 23'h600000;
  localparam int P_UP = 0, P_WAIT = 1, P_PEND = 2, P_SETTLE = 3;

  logic        clk25 = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        enable = 1'b1;
  logic [22:0] alive = ALL;
  logic        reset_fly, reset_spider, reset_mosquito, busy;
  logic [2:0]  group_cleared;
  logic [7:0]  wave;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #20 clk25 = ~clk25;

  enemy_respawn_scheduler #(.RESPAWN_FRAMES(RF), .SETTLE_MAX(SM)) dut (
    .clk25(clk25), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable),
    .enemy_alive_flat(alive), .reset_fly(reset_fly), .reset_spider(reset_spider),
    .reset_mosquito(reset_mosquito), .group_cleared(group_cleared), .wave(wave),
    .busy(busy)
  );

  // Model: per group, which phase of the respawn life it is in, how many
  // counted frames it still owes, and how long it has waited after a pulse.
  int         ph[3], owed[3], age[3];
  logic [2:0] m_pulse;
  int         m_wave;

  function automatic logic [22:0] gmask(input int g);
    case (g)
      0:       return FLY_M;
      1:       return SPI_M;
      default: return MOS_M;
    endcase
  endfunction

  task automatic model_reset();
    for (int g = 0; g < 3; g++) begin ph[g] = P_UP; owed[g] = 0; age[g] = 0; end
    m_pulse = '0;
    m_wave  = 0;
  endtask

  task automatic model_step();
    logic [2:0] gnt;
    logic       dead;
    gnt = '0;
    if (!rst_n) begin model_reset(); return; end
    if (m_pulse[0] && m_wave < 255) m_wave++;
    if (enable)
      for (int g = 0; g < 3; g++) if (ph[g] == P_PEND && gnt == 3'b000) gnt[g] = 1'b1;
    for (int g = 0; g < 3; g++) begin
`ifdef SCHED_ALL_CLEAR_EN
      dead = (alive == '0);
`else
      dead = ((alive & gmask(g)) == '0);
`endif
      case (ph[g])
        P_UP:   if (enable && dead) begin ph[g] = P_WAIT; owed[g] = RF; end
        P_WAIT: if (owed[g] == 0) ph[g] = P_PEND;
                else if (enable && frame_tick) owed[g]--;
        P_PEND: if (gnt[g]) begin ph[g] = P_SETTLE; age[g] = 0; end
        default: begin
          age[g]++;
          if ((alive & gmask(g)) != '0 || age[g] >= SM) ph[g] = P_UP;
        end
      endcase
    end
    m_pulse = gnt;
  endtask

  task automatic compare(input string tag, input logic [2:0] ep, input logic [2:0] ec,
                         input logic eb, input int ew);
    vectors++;
    if ({reset_mosquito, reset_spider, reset_fly} !== ep || group_cleared !== ec ||
        busy !== eb || wave !== ew[7:0]) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got pulse=%b cleared=%b busy=%b wave=%0d, want pulse=%b cleared=%b busy=%b wave=%0d",
               tag, cyc, {reset_mosquito, reset_spider, reset_fly}, group_cleared, busy, wave,
               ep, ec, eb, ew);
    end
  endtask

  task automatic check_model(input string tag);
    logic [2:0] ec;
    logic       eb;
    eb = 1'b0;
    for (int g = 0; g < 3; g++) begin
      ec[g] = (ph[g] == P_WAIT) || (ph[g] == P_PEND);
      if (ph[g] != P_UP) eb = 1'b1;
    end
    compare(tag, m_pulse, ec, eb, m_wave);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk25);
    model_step();
    #1;
    check_model(tag);
    cyc++;
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      frame_tick = (cyc % 10 == 0);
      cycle(tag);
    end
  endtask

  typedef struct {
    logic [22:0] a; logic en; logic tk; int n;
    logic [2:0] p; logic [2:0] c; logic b; int w;
  } row_t;
  row_t tbl[$];

  task automatic add(input logic [22:0] a, input logic en, input logic tk, input int n,
                     input logic [2:0] p, input logic [2:0] c, input logic b, input int w);
    row_t r;
    r.a = a; r.en = en; r.tk = tk; r.n = n; r.p = p; r.c = c; r.b = b; r.w = w;
    tbl.push_back(r);
  endtask

  initial begin
    int         bound;
    logic [22:0] m, nv;
    model_reset();
    repeat (3) cycle("in_reset");
    rst_n = 1'b1;
    run(100, "idle_after_reset");

`ifndef SCHED_ALL_CLEAR_EN
    // fly: clear, three ticks, request, pulse, revive
    add(ALL,          1, 0, 5, 3'b000, 3'b000, 0, 0);
    add(ALL & ~FLY_M, 1, 0, 1, 3'b000, 3'b001, 1, 0);
    add(ALL & ~FLY_M, 1, 1, 1, 3'b000, 3'b001, 1, 0);
    add(ALL & ~FLY_M, 1, 0, 2, 3'b000, 3'b001, 1, 0);
    add(ALL & ~FLY_M, 1, 1, 2, 3'b000, 3'b001, 1, 0);
    add(ALL & ~FLY_M, 1, 0, 1, 3'b000, 3'b001, 1, 0);
    add(ALL & ~FLY_M, 1, 0, 1, 3'b001, 3'b000, 1, 0);
    add(ALL & ~FLY_M, 1, 0, 1, 3'b000, 3'b000, 1, 1);
    add(ALL,          1, 0, 1, 3'b000, 3'b000, 0, 1);
    // mosquito stays dead: settle timeout then a second respawn
    add(ALL & ~MOS_M, 1, 0, 1, 3'b000, 3'b100, 1, 1);
    add(ALL & ~MOS_M, 1, 1, 3, 3'b000, 3'b100, 1, 1);
    add(ALL & ~MOS_M, 1, 0, 1, 3'b000, 3'b100, 1, 1);
    add(ALL & ~MOS_M, 1, 0, 1, 3'b100, 3'b000, 1, 1);
    add(ALL & ~MOS_M, 1, 0, 3, 3'b000, 3'b000, 1, 1);
    add(ALL & ~MOS_M, 1, 0, 1, 3'b000, 3'b000, 0, 1);
    add(ALL & ~MOS_M, 1, 0, 1, 3'b000, 3'b100, 1, 1);
    add(ALL & ~MOS_M, 1, 1, 3, 3'b000, 3'b100, 1, 1);
    add(ALL & ~MOS_M, 1, 0, 1, 3'b000, 3'b100, 1, 1);
    add(ALL & ~MOS_M, 1, 0, 1, 3'b100, 3'b000, 1, 1);
    add(ALL,          1, 0, 1, 3'b000, 3'b000, 0, 1);
    // fly and spider contend
    add(MOS_M,        1, 0, 1, 3'b000, 3'b011, 1, 1);
    add(MOS_M,        1, 1, 3, 3'b000, 3'b011, 1, 1);
    add(MOS_M,        1, 0, 1, 3'b000, 3'b011, 1, 1);
    add(MOS_M,        1, 0, 1, 3'b001, 3'b010, 1, 1);
    add(MOS_M,        1, 0, 1, 3'b010, 3'b000, 1, 2);
    add(ALL,          1, 0, 1, 3'b000, 3'b000, 0, 2);
    // enable low freezes cooldown and holds the request
    add(ALL & ~FLY_M, 1, 0, 1, 3'b000, 3'b001, 1, 2);
    add(ALL & ~FLY_M, 1, 1, 1, 3'b000, 3'b001, 1, 2);
    add(ALL & ~FLY_M, 0, 1, 5, 3'b000, 3'b001, 1, 2);
    add(ALL & ~FLY_M, 1, 1, 2, 3'b000, 3'b001, 1, 2);
    add(ALL & ~FLY_M, 1, 0, 1, 3'b000, 3'b001, 1, 2);
    add(ALL & ~FLY_M, 0, 0, 3, 3'b000, 3'b001, 1, 2);
    add(ALL & ~FLY_M, 1, 0, 1, 3'b001, 3'b000, 1, 2);
    add(ALL,          1, 0, 1, 3'b000, 3'b000, 0, 3);
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        alive = tbl[i].a; enable = tbl[i].en; frame_tick = tbl[i].tk;
        cycle("table_model");
        compare($sformatf("table_row%0d", i), tbl[i].p, tbl[i].c, tbl[i].b, tbl[i].w);
      end
    end
    frame_tick = 1'b0; enable = 1'b1;

    // reset while spider requests: abort, no pulse afterwards
    alive = ALL & ~SPI_M;
    bound = 0;
    while (ph[1] != P_PEND && bound < 200) begin run(1, "spider_to_req"); bound++; end
    vectors++;
    if (ph[1] != P_PEND) begin
      miscompares++;
      $display("FAIL spider_req_bound: model never reached request within %0d cycles", bound);
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    compare("async_reset_abort", 3'b000, 3'b000, 1'b0, 0);
    alive = ALL;
    run(3, "held_in_reset");
    rst_n = 1'b1;
    run(30, "after_abort");
`else
    alive = '0;
    cycle("all_clear_start");
    compare("all_clear_cooldown", 3'b000, 3'b111, 1'b1, 0);
    frame_tick = 1'b1;
    repeat (3) cycle("all_clear_ticks");
    frame_tick = 1'b0;
    cycle("all_clear_req");
    compare("all_clear_req", 3'b000, 3'b111, 1'b1, 0);
    cycle("all_clear_p0");
    compare("all_clear_fly", 3'b001, 3'b110, 1'b1, 0);
    cycle("all_clear_p1");
    compare("all_clear_spider", 3'b010, 3'b100, 1'b1, 1);
    cycle("all_clear_p2");
    compare("all_clear_mosq", 3'b100, 3'b000, 1'b1, 1);
    alive = ALL;
    run(10, "all_clear_revive");
`endif

    // randomized group kills, revivals, partial bits and pauses
    for (int i = 0; i < 4000; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      for (int g = 0; g < 3; g++) begin
        if ($urandom_range(0, 15) == 0) begin
          m = gmask(g);
          case ($urandom_range(0, 2))
            0:       nv = '0;
            1:       nv = m;
            default: nv = 23'($urandom()) & m;
          endcase
          alive = (alive & ~m) | nv;
        end
      end
      run(1, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
